// File: rtl/mmio_fabric.sv
// mmio_fabric: CPU data-port MMIO decoder with stalled, acknowledged transactions to NSLV slave windows
// plus built-in LED/switch registers. Define MMIO_TIMEOUT_EN to enable the BUSY timeout and err_cnt.
module mmio_fabric #(
  parameter int unsigned          DW       = 32,
  parameter int unsigned          AW       = 32,
  parameter int unsigned          NSLV     = 4,
  parameter logic [NSLV*AW-1:0]   SLV_BASE = {NSLV{32'h0}},
  parameter logic [NSLV*AW-1:0]   SLV_MASK = {NSLV{32'hFFFFFFFF}},
  parameter logic [AW-1:0]        LED_ADDR = 32'h0000C000,
  parameter logic [AW-1:0]        SW_ADDR  = 32'h0000C001,
  parameter int unsigned          LED_W    = 10,
  parameter int unsigned          SW_W     = 10,
  parameter int unsigned          TIMEOUT  = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [AW-1:0]        addr,
  input  logic                 re,
  input  logic                 we,
  input  logic [DW-1:0]        wdata,
  output logic [DW-1:0]        rdata,
  output logic                 stall,
  output logic [NSLV-1:0]      slv_sel,
  output logic                 slv_re,
  output logic                 slv_we,
  output logic [AW-1:0]        slv_addr,
  output logic [DW-1:0]        slv_wdata,
  input  logic [NSLV*DW-1:0]   slv_rdata,
  input  logic [NSLV-1:0]      slv_ack,
  output logic [LED_W-1:0]     led,
  input  logic [SW_W-1:0]      sw,
  output logic [7:0]           err_cnt
);

  if (NSLV < 1 || NSLV > 8 || TIMEOUT < 1) begin : g_param_check
    $error("mmio_fabric: NSLV must be 1..8 and TIMEOUT at least 1");
  end

  localparam logic [DW-1:0] DEAD = DW'(32'h0000DEAD);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state;

  logic [SW_W-1:0] sw_meta, sw_sync;
  logic            is_led, is_sw, slv_hit, found, ack_hit;
  logic [NSLV-1:0] hit_sel;
  logic [DW-1:0]   sel_rdata;

  // LED/SW decode outranks every window; among windows the lowest index wins.
  always_comb begin
    is_led  = (addr == LED_ADDR);
    is_sw   = (addr == SW_ADDR);
    hit_sel = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (!found && ((addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW])) begin
        hit_sel[i] = 1'b1;
        found      = 1'b1;
      end
    end
    slv_hit = found && !is_led && !is_sw;
  end

  always_comb begin
    sel_rdata = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      if (slv_sel[i]) sel_rdata = sel_rdata | slv_rdata[i*DW +: DW];
    end
    ack_hit = |(slv_ack & slv_sel);
  end

  assign stall = ((state == IDLE) && (re || we)) || (state == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

`ifdef MMIO_TIMEOUT_EN
  localparam int unsigned CW_RAW = $clog2(TIMEOUT + 1);
  localparam int unsigned CW     = (CW_RAW < 4) ? 4 : ((CW_RAW > 16) ? 16 : CW_RAW);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] busy_cnt;
`else
  assign err_cnt = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rdata     <= '0;
      slv_sel   <= '0;
      slv_re    <= 1'b0;
      slv_we    <= 1'b0;
      slv_addr  <= '0;
      slv_wdata <= '0;
      led       <= '0;
`ifdef MMIO_TIMEOUT_EN
      busy_cnt  <= '0;
      err_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (re || we) begin
            if (slv_hit) begin
              slv_sel   <= hit_sel;
              slv_re    <= re && !we;
              slv_we    <= we;
              slv_addr  <= addr;
              slv_wdata <= wdata;
`ifdef MMIO_TIMEOUT_EN
              busy_cnt  <= '0;
`endif
              state     <= BUSY;
            end else begin
              // A combined re+we is a write, so every write path answers zero.
              if (we)          rdata <= '0;
              else if (is_sw)  rdata <= DW'(sw_sync);
              else if (is_led) rdata <= '0;
              else             rdata <= DEAD;
              if (we && is_led) led <= wdata[LED_W-1:0];
              state <= RESP;
            end
          end
        end
        BUSY: begin
          if (ack_hit) begin
            rdata   <= slv_we ? '0 : sel_rdata;
            slv_sel <= '0;
            slv_re  <= 1'b0;
            slv_we  <= 1'b0;
            state   <= RESP;
          end
`ifdef MMIO_TIMEOUT_EN
          else if (busy_cnt == CNT_LAST) begin
            rdata   <= DEAD;
            slv_sel <= '0;
            slv_re  <= 1'b0;
            slv_we  <= 1'b0;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            state   <= RESP;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
`endif
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_fabric.sv
// Scoreboard bench for mmio_fabric: the driver pushes expected read data, a negedge monitor pops on each response.
module tb_mmio_fabric;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   addr = '0;
  logic          re = 1'b0;
  logic          we = 1'b0;
  logic [31:0]   wdata = '0;
  logic [31:0]   rdata;
  logic          stall;
  logic [3:0]    slv_sel;
  logic          slv_re, slv_we;
  logic [31:0]   slv_addr, slv_wdata;
  logic [127:0]  slv_rdata = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
  logic [3:0]    slv_ack = '0;
  logic [9:0]    led;
  logic [9:0]    sw = 10'h2A5;
  logic [7:0]    err_cnt;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  int ack_delay = 0;
  int ack_slave = 0;
  bit stray = 1'b0;
  int busy_n = 0;

  always #5 clk = ~clk;

  mmio_fabric #(
    .DW(32), .AW(32), .NSLV(4),
    .SLV_BASE({32'h0000_C000, 32'h0002_0000, 32'h0001_0000, 32'h0002_0000}),
    .SLV_MASK({32'hFFFF_F000, 32'hFFFE_0000, 32'hFFFF_0000, 32'hFFFF_0000}),
    .LED_ADDR(32'h0000_C000), .SW_ADDR(32'h0000_C001),
    .LED_W(10), .SW_W(10), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .re(re), .we(we), .wdata(wdata),
    .rdata(rdata), .stall(stall), .slv_sel(slv_sel), .slv_re(slv_re), .slv_we(slv_we),
    .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_rdata(slv_rdata), .slv_ack(slv_ack),
    .led(led), .sw(sw), .err_cnt(err_cnt)
  );

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endfunction

  // Slave model: acks the chosen slave on the ack_delay-th strobed cycle; optional stray ack on slave 0.
  always @(negedge clk) begin
    slv_ack = '0;
    if (slv_re || slv_we) begin
      busy_n++;
      if (ack_delay != 0 && busy_n == ack_delay) slv_ack[ack_slave] = 1'b1;
      if (stray && busy_n == 1 && ack_slave != 0) slv_ack[0] = 1'b1;
    end else begin
      busy_n = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && (re || we) && !stall) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_response", rdata, 32'hXXXX_XXXX);
      end else begin
        chk(name_q.pop_front(), rdata, exp_q.pop_front());
      end
    end
  end

  task automatic access(input string nm, input logic [31:0] a, input logic r, input logic w,
                        input logic [31:0] d, input logic [31:0] exp, input int exp_stall,
                        input int exp_strobe, input logic [1:0] exp_kind, input logic [3:0] exp_sel);
    int stall_n = 0;
    int strobe_n = 0;
    logic [1:0]  kind_seen = '0;
    logic [3:0]  sel_seen = '0;
    logic [31:0] addr_seen = '0;
    logic [31:0] wdata_seen = '0;
    @(posedge clk); #1;
    addr = a; re = r; we = w; wdata = d;
    exp_q.push_back(exp);
    name_q.push_back({"rdata_", nm});
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (slv_re || slv_we) begin
        if (strobe_n == 0) begin
          kind_seen = {slv_re, slv_we};
          sel_seen = slv_sel;
          addr_seen = slv_addr;
          wdata_seen = slv_wdata;
        end
        strobe_n++;
      end
      if (!stall) break;
      stall_n++;
    end
    chk({"stall_cycles_", nm}, stall_n, exp_stall);
    chk({"strobe_cycles_", nm}, strobe_n, exp_strobe);
    chk({"strobe_kind_", nm}, {30'b0, kind_seen}, {30'b0, exp_kind});
    chk({"slv_sel_", nm}, {28'b0, sel_seen}, {28'b0, exp_sel});
    if (exp_strobe > 0) begin
      chk({"slv_addr_", nm}, addr_seen, a);
      if (w) chk({"slv_wdata_", nm}, wdata_seen, d);
    end
    @(posedge clk); #1;
    re = 1'b0; we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_slv_sel", {28'b0, slv_sel}, 32'h0);
    chk("rst_strobes", {30'b0, slv_re, slv_we}, 32'h0);
    chk("rst_slv_addr", slv_addr, 32'h0);
    chk("rst_slv_wdata", slv_wdata, 32'h0);
    chk("rst_led", {22'b0, led}, 32'h0);
    chk("rst_err_cnt", {24'b0, err_cnt}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    access("sw_read", 32'h0000_C001, 1'b1, 1'b0, 32'h0, 32'h0000_02A5, 1, 0, 2'b00, 4'b0000);
    access("led_write", 32'h0000_C000, 1'b0, 1'b1, 32'hFFFF_F155, 32'h0, 1, 0, 2'b00, 4'b0000);
    chk("led_after_write", {22'b0, led}, 32'h155);
    access("led_rw", 32'h0000_C000, 1'b1, 1'b1, 32'h0000_00AA, 32'h0, 1, 0, 2'b00, 4'b0000);
    chk("led_after_rw", {22'b0, led}, 32'h0AA);

    sw = 10'h15A;
    repeat (3) @(posedge clk);
    access("sw_read2", 32'h0000_C001, 1'b1, 1'b0, 32'h0, 32'h0000_015A, 1, 0, 2'b00, 4'b0000);
    access("sw_write", 32'h0000_C001, 1'b0, 1'b1, 32'h0000_FFFF, 32'h0, 1, 0, 2'b00, 4'b0000);
    chk("led_after_sw_write", {22'b0, led}, 32'h0AA);

    ack_slave = 1; ack_delay = 3; stray = 1'b1;
    access("slv1_read", 32'h0001_0004, 1'b1, 1'b0, 32'h0, 32'hCAFE_0001, 4, 3, 2'b10, 4'b0010);
    stray = 1'b0;

    access("unmapped_read", 32'h0000_5000, 1'b1, 1'b0, 32'h0, 32'h0000_DEAD, 1, 0, 2'b00, 4'b0000);
    access("unmapped_write", 32'h0000_5000, 1'b0, 1'b1, 32'h1111_2222, 32'h0, 1, 0, 2'b00, 4'b0000);

    ack_slave = 2; ack_delay = 1;
    access("slv2_write", 32'h0003_0008, 1'b0, 1'b1, 32'h1234_5678, 32'h0, 2, 1, 2'b01, 4'b0100);
    ack_slave = 0; ack_delay = 2;
    access("slv0_overlap_read", 32'h0002_0000, 1'b1, 1'b0, 32'h0, 32'hCAFE_0000, 3, 2, 2'b10, 4'b0001);
    ack_slave = 3; ack_delay = 1;
    access("slv3_read", 32'h0000_C010, 1'b1, 1'b0, 32'h0, 32'hCAFE_0003, 2, 1, 2'b10, 4'b1000);
    chk("led_after_slave_traffic", {22'b0, led}, 32'h0AA);

    // Reset while BUSY: strobes must fall without waiting for a clock edge.
    ack_slave = 0; ack_delay = 0;
    @(posedge clk); #1;
    addr = 32'h0002_0010; re = 1'b1;
    repeat (2) @(negedge clk);
    chk("busy_re_before_reset", {31'b0, slv_re}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("reset_slv_re", {31'b0, slv_re}, 32'h0);
    chk("reset_slv_sel", {28'b0, slv_sel}, 32'h0);
    chk("reset_led", {22'b0, led}, 32'h0);
    re = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    ack_slave = 1; ack_delay = 1;
    access("slv1_after_reset", 32'h0001_FFFC, 1'b1, 1'b0, 32'h0, 32'hCAFE_0001, 2, 1, 2'b10, 4'b0010);

`ifdef MMIO_TIMEOUT_EN
    ack_slave = 0; ack_delay = 15;
    access("ack_at_expiry", 32'h0002_0020, 1'b1, 1'b0, 32'h0, 32'hCAFE_0000, 16, 15, 2'b10, 4'b0001);
    chk("err_after_ack_at_expiry", {24'b0, err_cnt}, 32'h0);
    ack_delay = 0;
    access("timeout_read", 32'h0002_0024, 1'b1, 1'b0, 32'h0, 32'h0000_DEAD, 16, 15, 2'b10, 4'b0001);
    chk("err_after_first_timeout", {24'b0, err_cnt}, 32'h1);
    access("timeout_write", 32'h0002_0028, 1'b0, 1'b1, 32'hAAAA_5555, 32'h0000_DEAD, 16, 15, 2'b01, 4'b0001);
    chk("err_after_second_timeout", {24'b0, err_cnt}, 32'h2);
    for (int k = 0; k < 298; k++) begin
      access("timeout_bulk", 32'h0002_0030, 1'b1, 1'b0, 32'h0, 32'h0000_DEAD, 16, 15, 2'b10, 4'b0001);
    end
    chk("err_saturated", {24'b0, err_cnt}, 32'hFF);
`else
    chk("err_cnt_tied_zero", {24'b0, err_cnt}, 32'h0);
`endif

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
